// File: rtl/icmp_echo_ctrl.sv
// ICMP echo controller: captures an echo-request body into the payload
// buffer, closes it, checks the buffer's size, then arbitrates for the shared
// TX word path and streams the stored reply out under valid/ready.
module icmp_echo_ctrl #(
  parameter int MAX_WORDS   = 255,
  parameter int SETTLE      = 3,
  parameter int GNT_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_icmp_start,
  input  logic        i_icmp_valid,
  input  logic [31:0] i_icmp_data,
  input  logic        i_icmp_end,
  output logic        o_buf_start,
  output logic        o_buf_wren,
  output logic [31:0] o_buf_data,
  output logic        o_buf_eop,
  input  logic [7:0]  i_buf_size,
  input  logic [31:0] i_buf_data,
  output logic        o_buf_rdy,
  output logic        o_tx_req,
  input  logic        i_tx_gnt,
  output logic        o_tx_valid,
  output logic [31:0] o_tx_data,
  output logic        o_tx_last,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic [7:0]  o_drop_cnt,
  output logic [15:0] o_reply_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CAP    = 3'd1;
  localparam logic [2:0] S_FLUSH  = 3'd2;
  localparam logic [2:0] S_CLOSE  = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
  localparam logic [2:0] S_REQ    = 3'd5;
  localparam logic [2:0] S_REWIND = 3'd6;
  localparam logic [2:0] S_SEND   = 3'd7;

  // Shared counter for the 2-cycle eop pulse and the settle wait.
  localparam int SW = $clog2(SETTLE + 2);
  localparam int TW = $clog2(GNT_TIMEOUT + 1);

  logic [2:0]    state;
  logic [8:0]    wcnt;
  logic [7:0]    n;
  logic [7:0]    rcnt;
  logic [SW-1:0] ccnt;
  logic [TW-1:0] tcnt;

  logic       rx_start, rx_end, rx_open;
  logic       cap_ovf, settle_done, size_bad, gnt_tmo;
  logic       busy_drop, fsm_drop, accept, last_word;
  logic [7:0] size_m1;
  logic [8:0] drop_sum;

  assign rx_start = i_icmp_valid & i_icmp_start;
  assign rx_end   = i_icmp_valid & i_icmp_end;
  // States where an incoming start word is accepted rather than dropped.
  assign rx_open  = (state == S_IDLE) | (state == S_CAP);

  // A non-start word that would push the body past MAX_WORDS aborts capture.
  assign cap_ovf     = (state == S_CAP) & i_icmp_valid & ~i_icmp_start &
                       (wcnt >= 9'(MAX_WORDS));
  assign settle_done = (state == S_SETTLE) & (ccnt == SW'(SETTLE - 1));
  assign size_m1     = i_buf_size - 8'd1;
  assign size_bad    = {1'b0, size_m1} != wcnt;
  assign gnt_tmo     = (state == S_REQ) & ~i_tx_gnt & (tcnt == TW'(GNT_TIMEOUT - 1));

  assign busy_drop = rx_start & ~rx_open;
  assign fsm_drop  = cap_ovf | (settle_done & size_bad) | gnt_tmo;
  assign drop_sum  = {1'b0, o_drop_cnt} + {8'd0, busy_drop} + {8'd0, fsm_drop};

  assign accept    = (state == S_SEND) & i_tx_ready;
  assign last_word = rcnt == (n - 8'd1);

  // Buffer and TX strobes decode straight from state so reset clears them at once.
  always_comb begin
    o_buf_data  = i_icmp_data;
    o_buf_wren  = ((state == S_IDLE) & rx_start) |
                  ((state == S_CAP) & i_icmp_valid & ~cap_ovf);
    o_buf_start = (rx_open & rx_start) | (state == S_REWIND);
    o_buf_eop   = state == S_CLOSE;
    o_buf_rdy   = accept;
    o_tx_req    = (state == S_REQ) | (state == S_REWIND) | (state == S_SEND);
    o_tx_valid  = state == S_SEND;
    o_tx_data   = (state == S_SEND) ? i_buf_data : 32'd0;
    o_tx_last   = (state == S_SEND) & last_word;
    o_busy      = state != S_IDLE;
  end

  // Sequencer: capture -> close -> settle -> request -> rewind -> send.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      wcnt  <= '0;
      n     <= '0;
      rcnt  <= '0;
      ccnt  <= '0;
      tcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ccnt <= '0;
          if (rx_start) begin
            wcnt  <= 9'd1;
            state <= i_icmp_end ? S_CLOSE : S_CAP;
          end
        end
        S_CAP: begin
          ccnt <= '0;
          if (i_icmp_valid) begin
            if (i_icmp_start) begin
              // Restart: this word becomes word 0 of a fresh body.
              wcnt  <= 9'd1;
              state <= i_icmp_end ? S_CLOSE : S_CAP;
            end else if (cap_ovf) begin
              state <= i_icmp_end ? S_IDLE : S_FLUSH;
            end else begin
              wcnt <= wcnt + 9'd1;
              if (i_icmp_end) state <= S_CLOSE;
            end
          end
        end
        S_FLUSH: begin
          if (rx_end) state <= S_IDLE;
        end
        S_CLOSE: begin
          // Two eop cycles so the buffer's edge detector always sees a rise.
          if (ccnt == SW'(1)) begin
            ccnt  <= '0;
            state <= S_SETTLE;
          end else begin
            ccnt <= ccnt + SW'(1);
          end
        end
        S_SETTLE: begin
          if (settle_done) begin
            n     <= size_m1;
            tcnt  <= '0;
            state <= size_bad ? S_IDLE : S_REQ;
          end else begin
            ccnt <= ccnt + SW'(1);
          end
        end
        S_REQ: begin
          if (i_tx_gnt)     state <= S_REWIND;
          else if (gnt_tmo) state <= S_IDLE;
          else              tcnt  <= tcnt + TW'(1);
        end
        S_REWIND: begin
          rcnt  <= '0;
          state <= S_SEND;
        end
        S_SEND: begin
          if (accept) begin
            rcnt <= rcnt + 8'd1;
            if (last_word) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Drop counter saturates; reply counter wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_drop_cnt  <= '0;
      o_reply_cnt <= '0;
    end else begin
      o_drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      if (accept & last_word) o_reply_cnt <= o_reply_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_icmp_echo_ctrl.sv
// Bench for icmp_echo_ctrl: a behavioural payload buffer, an expected-reply
// queue checked on every accepted TX word, and directed frame scenarios.
module tb_icmp_echo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        icmp_start, icmp_valid, icmp_end;
  logic [31:0] icmp_data;
  logic        buf_start, buf_wren, buf_eop, buf_rdy;
  logic [31:0] buf_wdata, buf_rdata;
  logic [7:0]  buf_size;
  logic        tx_req, tx_gnt, tx_valid, tx_last, tx_ready;
  logic [31:0] tx_data;
  logic        busy;
  logic [7:0]  drop_cnt;
  logic [15:0] reply_cnt;

  always #5 clk = ~clk;

  icmp_echo_ctrl #(.MAX_WORDS(255), .SETTLE(3), .GNT_TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst),
    .i_icmp_start(icmp_start), .i_icmp_valid(icmp_valid),
    .i_icmp_data(icmp_data), .i_icmp_end(icmp_end),
    .o_buf_start(buf_start), .o_buf_wren(buf_wren), .o_buf_data(buf_wdata),
    .o_buf_eop(buf_eop), .i_buf_size(buf_size), .i_buf_data(buf_rdata),
    .o_buf_rdy(buf_rdy), .o_tx_req(tx_req), .i_tx_gnt(tx_gnt),
    .o_tx_valid(tx_valid), .o_tx_data(tx_data), .o_tx_last(tx_last),
    .i_tx_ready(tx_ready), .o_busy(busy), .o_drop_cnt(drop_cnt),
    .o_reply_cnt(reply_cnt)
  );

  // Payload buffer model: word store, read pointer, size latched on eop rise.
  logic [31:0] bmem [0:255];
  logic [7:0]  wptr = 8'd0, rptr = 8'd0, bsize = 8'd0;
  logic        eop_q = 1'b0;
  assign buf_rdata = bmem[rptr];
  assign buf_size  = bsize;

  always @(posedge clk) begin
    eop_q <= buf_eop;
    if (buf_wren) begin
      if (buf_start) begin bmem[0] <= buf_wdata; wptr <= 8'd1; end
      else begin bmem[wptr] <= buf_wdata; wptr <= wptr + 8'd1; end
    end else if (buf_start) rptr <= 8'd0;
    if (buf_rdy) rptr <= rptr + 8'd1;
    if (buf_eop && !eop_q) bsize <= wptr + 8'd1;
  end

  // Arbiter: grants gnt_delay cycles after the request rises; -1 never grants.
  int gnt_delay = 10;
  int req_run   = 0;
  assign tx_gnt = tx_req && (gnt_delay >= 0) && (req_run >= gnt_delay);

  int n_tests = 0, n_fail = 0;
  logic [32:0] exp_mem [0:255];
  int exp_wr = 0, exp_rd = 0;
  int acc_cnt = 0, eop_cyc = 0, rew_cyc = 0, wr_cyc = 0, rdy_cyc = 0, req_tot = 0, tv_cyc = 0;
  int b_acc, b_eop, b_rew, b_wr, b_rdy, b_req, b_tv;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = 32'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic last);
    exp_mem[exp_wr % 256] = {last, d};
    exp_wr++;
  endtask

  task automatic snap();
    b_acc = acc_cnt; b_eop = eop_cyc; b_rew = rew_cyc; b_wr = wr_cyc;
    b_rdy = rdy_cyc; b_req = req_tot; b_tv = tv_cyc;
  endtask

  // Per-cycle observer: event counts, stall hold, TX stream vs expected queue.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_rd = exp_wr; stall_prev = 1'b0; req_run = 0;
      end else begin
        eop_cyc += int'(buf_eop);
        rew_cyc += int'(buf_start && !buf_wren);
        wr_cyc  += int'(buf_wren);
        rdy_cyc += int'(buf_rdy);
        req_tot += int'(tx_req);
        tv_cyc  += int'(tx_valid);
        req_run  = tx_req ? req_run + 1 : 0;
        chk("buf_rdy", buf_rdy, tx_valid && tx_ready);
        if (stall_prev) chk("stall_hold", {tx_valid, tx_data}, {1'b1, stall_data});
        if (tx_valid && tx_ready) begin
          if (exp_rd == exp_wr) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_tx: got %0h expected none", tx_data);
          end else begin
            chk("tx_data", tx_data, exp_mem[exp_rd % 256][31:0]);
            chk("tx_last", tx_last, exp_mem[exp_rd % 256][32]);
            exp_rd++;
          end
          acc_cnt++;
        end
        stall_prev = tx_valid && !tx_ready;
        stall_data = tx_data;
      end
    end
  endtask

  task automatic word(input logic s, input logic e, input logic [31:0] d);
    icmp_start = s; icmp_end = e; icmp_data = d; icmp_valid = 1'b1;
    @(posedge clk); #1;
    icmp_valid = 1'b0; icmp_start = 1'b0; icmp_end = 1'b0;
  endtask

  task automatic frame(input int nw, input logic [31:0] first, input logic [31:0] base, input bit expect_reply);
    logic [31:0] d;
    for (int i = 0; i < nw; i++) begin
      d = (i == 0) ? first : base + 32'(i);
      if (expect_reply) push(d, i == nw - 1);
      word(i == 0, i == nw - 1, d);
    end
  endtask

  task automatic wait_idle(input int lim, input string nm);
    int k = 0;
    while (busy && k < lim) begin @(posedge clk); #1; k++; end
    chk(nm, busy, 1'b0);
  endtask

  task automatic wait_valid(input int lim, input string nm);
    int k = 0;
    while (!tx_valid && k < lim) begin @(posedge clk); #1; k++; end
    chk(nm, tx_valid, 1'b1);
  endtask

  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int k;
    rst = 1'b1; icmp_start = 1'b0; icmp_valid = 1'b0; icmp_end = 1'b0;
    icmp_data = 32'd0; tx_ready = 1'b1;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_outs", {buf_start, buf_wren, buf_eop, buf_rdy, tx_req, tx_valid, tx_last}, 0);
    chk("rst_cnts", {drop_cnt, reply_cnt}, 0);
    rst = 1'b0;

    // 1: basic 4-word echo, ready high
    snap();
    frame(4, 32'h0800ABCD, 32'h1000_0000, 1);
    wait_idle(3000, "t1_idle");
    chk("t1_eop_cycles", eop_cyc - b_eop, 2);
    chk("t1_rewind", rew_cyc - b_rew, 1);
    chk("t1_accepts", acc_cnt - b_acc, 4);
    chk("t1_valid_cycles", tv_cyc - b_tv, 4);
    chk("t1_reply", reply_cnt, 1);
    chk("t1_drop", drop_cnt, 0);
    chk("t1_word0", bmem[0], 32'h0800ABCD);
    chk("t1_word3", bmem[3], 32'h1000_0003);
    chk("t1_size", bsize, 5);
    chk("t1_queue", exp_wr - exp_rd, 0);

    // 2: ready toggled 1,0,0,1 during send
    tx_ready = 1'b0;
    snap();
    frame(4, 32'h0800ABCD, 32'h2000_0000, 1);
    wait_valid(200, "t2_valid");
    foreach (pat[i]) begin tx_ready = pat[i]; @(posedge clk); #1; end
    tx_ready = 1'b1;
    wait_idle(200, "t2_idle");
    chk("t2_rdy_pulses", rdy_cyc - b_rdy, 4);
    chk("t2_valid_cycles", tv_cyc - b_tv, 6);
    chk("t2_reply", reply_cnt, 2);
    chk("t2_queue", exp_wr - exp_rd, 0);

    // 3: grant never arrives
    gnt_delay = -1;
    snap();
    frame(4, 32'h0800ABCD, 32'h3000_0000, 0);
    wait_idle(3000, "t3_idle");
    chk("t3_req_cycles", req_tot - b_req, 1024);
    chk("t3_drop", drop_cnt, 1);
    chk("t3_no_valid", tv_cyc - b_tv, 0);
    chk("t3_reply", reply_cnt, 2);
    gnt_delay = 10;

    // 4: oversize frame, then a 1-word frame
    snap();
    frame(256, 32'hAAAA_0000, 32'h4000_0000, 0);
    wait_idle(100, "t4_idle");
    chk("t4_writes", wr_cyc - b_wr, 255);
    chk("t4_no_eop", eop_cyc - b_eop, 0);
    chk("t4_drop", drop_cnt, 2);
    snap();
    frame(1, 32'h0800BEEF, 32'h0, 1);
    wait_idle(200, "t4b_idle");
    chk("t4b_size", bsize, 2);
    chk("t4b_accepts", acc_cnt - b_acc, 1);
    chk("t4b_reply", reply_cnt, 3);
    chk("t4b_queue", exp_wr - exp_rd, 0);

    // 5: new request arrives during send
    frame(4, 32'h0800ABCD, 32'h5000_0000, 1);
    wait_valid(200, "t5_valid");
    snap();
    frame(3, 32'h0800DEAD, 32'h5500_0000, 0);
    wait_idle(200, "t5_idle");
    chk("t5_no_write", wr_cyc - b_wr, 0);
    chk("t5_drop", drop_cnt, 3);
    chk("t5_accepts", acc_cnt - b_acc, 4);
    chk("t5_reply", reply_cnt, 4);
    chk("t5_queue", exp_wr - exp_rd, 0);

    // 6: reset after word 2 of 4
    snap();
    frame(4, 32'h0800ABCD, 32'h6000_0000, 1);
    k = 0;
    while ((acc_cnt - b_acc) < 2 && k < 300) begin @(posedge clk); #1; k++; end
    chk("t6_two_acc", acc_cnt - b_acc, 2);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_outs", {busy, buf_start, buf_wren, buf_eop, buf_rdy, tx_req, tx_valid, tx_last}, 0);
    chk("t6_rst_data", tx_data, 0);
    chk("t6_rst_cnts", {drop_cnt, reply_cnt}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    snap();
    frame(2, 32'h0800ABCD, 32'h7000_0000, 1);
    wait_idle(200, "t6_idle");
    chk("t6_accepts", acc_cnt - b_acc, 2);
    chk("t6_reply", reply_cnt, 1);
    chk("t6_drop", drop_cnt, 0);
    chk("t6_queue", exp_wr - exp_rd, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icmp_echo_ctrl.md
Name: icmp_echo_ctrl

Overview:
Sequencer wrapped around the ICMP echo payload buffer. Captures an echo-request body from the RX parser into the buffer, closes it so the buffer latches size and checksum, then arbitrates for the shared Ethernet TX word path. Streams the stored reply out under valid/ready. Owns all buffer control strobes (start, write enable, end-of-packet, read advance).

Parameters:
MAX_WORDS, 255, largest accepted body in 32-bit words; a longer capture is aborted.
SETTLE, 3, idle cycles after end-of-packet assertion before buffer size/checksum are sampled.
GNT_TIMEOUT, 1024, cycles to wait for TX grant before dropping the reply.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
i_icmp_start  in  1  qualifies first body word; meaningful only with i_icmp_valid
i_icmp_valid  in  1  body word valid
i_icmp_data  in  32  body word
i_icmp_end  in  1  last body word; meaningful only with i_icmp_valid
o_buf_start  out  1  buffer start strobe (with wren: write word 0; alone: rewind read pointer)
o_buf_wren  out  1  buffer write enable
o_buf_data  out  32  buffer write data
o_buf_eop  out  1  buffer end-of-packet level
i_buf_size  in  8  buffer payload size (equals words written + 1)
i_buf_data  in  32  buffer read data (combinational from read pointer)
o_buf_rdy  out  1  buffer read-pointer advance
o_tx_req  out  1  request for shared TX path
i_tx_gnt  in  1  grant from TX arbiter
o_tx_valid  out  1  TX word valid
o_tx_data  out  32  TX word
o_tx_last  out  1  final TX word
i_tx_ready  in  1  TX sink ready
o_busy  out  1  high in any state except IDLE
o_drop_cnt  out  8  dropped requests, saturating at 255
o_reply_cnt  out  16  completed replies, wrapping

Behaviour:
- Reset (async, any state): state IDLE. All strobes, o_tx_*, o_busy = 0. o_drop_cnt = 0, o_reply_cnt = 0, word counters = 0.
- o_buf_data = i_icmp_data, combinational. In CAPTURE: o_buf_wren = i_icmp_valid, o_buf_start = i_icmp_valid & i_icmp_start.
- IDLE: on i_icmp_valid & i_icmp_start go to CAPTURE. The start word is written the same cycle and wcnt = 1. If that word also carries i_icmp_end, go directly to CLOSE.
- CAPTURE: each valid word increments wcnt. On the valid word with i_icmp_end go to CLOSE.
  - Valid with i_icmp_start again: restart. The word is written as word 0 and wcnt = 1; no drop is counted.
  - wcnt would exceed MAX_WORDS: stop writing, drop_cnt +1, go to FLUSH.
- FLUSH: ignore words until the valid word with i_icmp_end, then go to IDLE. o_buf_eop stays low.
- CLOSE: o_buf_eop = 1 for exactly 2 cycles (guarantees a rise for the buffer's edge detector), then go to SETTLE. All words are written before eop rises.
- SETTLE: wait SETTLE cycles, register n = i_buf_size - 1, go to REQ. If n != wcnt, drop_cnt +1 and go to IDLE.
- REQ: o_tx_req = 1 and a timeout counter runs.
  - On i_tx_gnt go to REWIND.
  - After GNT_TIMEOUT cycles without grant: drop_cnt +1, go to IDLE.
  - o_tx_req stays high from REQ through the cycle the last word is accepted.
- REWIND: o_buf_start = 1 with o_buf_wren = 0 for one cycle (read pointer to 0), then go to SEND with rcnt = 0.
- SEND:
  - o_tx_valid = 1, o_tx_data = i_buf_data, o_tx_last = (rcnt == n-1).
  - Accept = o_tx_valid & i_tx_ready. o_buf_rdy = accept; rcnt increments on accept.
  - Data must hold while i_tx_ready = 0; the buffer pointer does not move without o_buf_rdy.
  - Accept of the last word: reply_cnt +1, go to IDLE the next cycle.
  - Word 0 out of the buffer already holds the checksum; the controller does not modify data.
- New requests while busy (any state except IDLE/CAPTURE): the start word is not written, drop_cnt +1 once per i_icmp_start, and the rest of that frame is ignored.
- Loss of i_tx_gnt during SEND is ignored: the arbiter must hold the grant while o_tx_req is high.
- Strobes in all other states are 0. o_busy = (state != IDLE).

Test Plan:
- 4-word request (start word 0x0800ABCD, end on word 4), buffer returns size 5, grant after 10 cycles, ready held high -> o_buf_eop high exactly 2 cycles; one REWIND start pulse with wren = 0; 4 TX words with o_tx_last on the 4th; o_reply_cnt = 1.
- Same frame, i_tx_ready toggled 1,0,0,1 during SEND -> o_tx_data stable while stalled; o_buf_rdy pulses = 4 total; no word skipped or duplicated.
- Grant never asserted -> o_tx_req drops after 1024 cycles; o_drop_cnt = 1; state IDLE; no o_tx_valid.
- 256-word frame -> writes stop after 255; o_buf_eop never asserted; o_drop_cnt +1; next 1-word frame replies normally with n = 1 and o_tx_last on the first word.
- Second i_icmp_start arrives during SEND -> no buffer write; o_drop_cnt +1; current reply completes intact.
- rst pulsed mid-SEND (after word 2 of 4) -> all outputs 0 immediately; counters cleared; next frame processed from IDLE.
